// File: rtl/tick_scheduler.sv
// Shared BASE_HZ prescaler driving four independently periodised one-cycle tick channels.
// Optional macro TICK_SCHED_SYNC_CFG_EN defers each accepted config to the next base event (PEND state).
module tick_scheduler #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BASE_HZ = 100,
    parameter int PW      = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [1:0]    cfg_ch,
    input  logic [PW-1:0] cfg_period,
    input  logic          cfg_start,
    output logic          cfg_err,
    output logic          base_tick,
    output logic [3:0]    tick,
    output logic [3:0]    running
);
    localparam int DIV = CLK_HZ / BASE_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 1);

    logic [CW-1:0]      pre_q, pre_d;
    logic               ev;
    logic               base_tick_q;
    logic               err_q;
    logic [3:0][PW-1:0] period_q, period_d;
    logic [3:0][PW-1:0] cnt_q, cnt_d;
    logic [3:0]         run_q, run_d;
    logic [3:0]         tick_q, tick_d;

    logic               accept;
    logic               cfg_bad;
    logic               app_vld;
    logic               app_start;
    logic [1:0]         app_ch;
    logic [PW-1:0]      app_period;

    assign ev      = (pre_q == PRE_LAST);
    assign pre_d   = ev ? '0 : pre_q + CW'(1);
    assign accept  = cfg_valid && cfg_ready;
    assign cfg_bad = cfg_start && (cfg_period == '0);

`ifdef TICK_SCHED_SYNC_CFG_EN
    typedef enum logic {S_IDLE, S_PEND} state_t;

    state_t        state_q, state_d;
    logic [1:0]    req_ch_q, req_ch_d;
    logic [PW-1:0] req_period_q, req_period_d;
    logic          req_start_q, req_start_d;

    assign cfg_ready  = (state_q == S_IDLE);
    assign app_ch     = req_ch_q;
    assign app_period = req_period_q;
    assign app_start  = req_start_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            req_ch_q     <= '0;
            req_period_q <= '0;
            req_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ch_q     <= req_ch_d;
            req_period_q <= req_period_d;
            req_start_q  <= req_start_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ch_d     = req_ch_q;
        req_period_d = req_period_q;
        req_start_d  = req_start_q;
        app_vld      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Rejected requests never enter PEND, so they cannot touch channel state.
                if (cfg_valid && !cfg_bad) begin
                    req_ch_d     = cfg_ch;
                    req_period_d = cfg_period;
                    req_start_d  = cfg_start;
                    state_d      = S_PEND;
                end
            end
            S_PEND: begin
                if (ev) begin
                    app_vld = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
`else
    assign cfg_ready  = 1'b1;
    assign app_vld    = accept && !cfg_bad;
    assign app_ch     = cfg_ch;
    assign app_period = cfg_period;
    assign app_start  = cfg_start;
`endif

    // A config landing on a channel overrides that channel's countdown for this base event.
    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        tick_d   = '0;
        for (int i = 0; i < 4; i++) begin
            if (app_vld && (app_ch == 2'(i))) begin
                if (app_start) begin
                    period_d[i] = app_period;
                    cnt_d[i]    = app_period;
                    run_d[i]    = 1'b1;
                end else begin
                    cnt_d[i] = '0;
                    run_d[i] = 1'b0;
                end
            end else if (ev && run_q[i]) begin
                if (cnt_q[i] == PW'(1)) begin
                    tick_d[i] = 1'b1;
                    cnt_d[i]  = period_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] - PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q       <= '0;
            base_tick_q <= 1'b0;
            err_q       <= 1'b0;
            period_q    <= '0;
            cnt_q       <= '0;
            run_q       <= '0;
            tick_q      <= '0;
        end else begin
            pre_q       <= pre_d;
            base_tick_q <= ev;
            err_q       <= accept && cfg_bad;
            period_q    <= period_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            tick_q      <= tick_d;
        end
    end

    assign base_tick = base_tick_q;
    assign cfg_err   = err_q;
    assign tick      = tick_q;
    assign running   = run_q;
endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler at DIV=10; expectations cover both builds of TICK_SCHED_SYNC_CFG_EN.
module tb_tick_scheduler;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_period = '0;
    logic       cfg_start = 1'b0;
    logic       cfg_err;
    logic       base_tick;
    logic [3:0] tick;
    logic [3:0] running;

    int n_vec  = 0;
    int n_miss = 0;
    int edge_n = 0;

`ifdef TICK_SCHED_SYNC_CFG_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    tick_scheduler #(.CLK_HZ(1000), .BASE_HZ(100), .PW(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_start  (cfg_start),
        .cfg_err    (cfg_err),
        .base_tick  (base_tick),
        .tick       (tick),
        .running    (running)
    );

    always #5 clk = ~clk;

    // Edge index relative to the latest reset release: edge 1 is the first rising edge after it.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_n <= 0;
        else          edge_n <= edge_n + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, edge_n=%0d expected completion", edge_n);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic to_edge(input int k);
        while (edge_n < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req(input int at, input logic [1:0] ch, input logic [7:0] p, input logic st);
        to_edge(at - 1);
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_period = p;
        cfg_start  = st;
        to_edge(at);
        cfg_valid  = 1'b0;
    endtask

    logic [3:0] tk_exp [17];
    int         stop_edge;
    bit         stop_done;

    initial begin
        if (SYNC) begin
            tk_exp = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h3, 4'h6, 4'h2, 4'h7, 4'h2, 4'h6,
                       4'h3, 4'h6, 4'h2, 4'h6, 4'h2, 4'h6, 4'h2};
            stop_edge = 122;
        end else begin
            tk_exp = '{4'h0, 4'h0, 4'h2, 4'h3, 4'h6, 4'h2, 4'h7, 4'h2, 4'h6, 4'h3,
                       4'h6, 4'h2, 4'h7, 4'h2, 4'h6, 4'h2, 4'h6};
            stop_edge = 150;
        end
        stop_done = 1'b0;

        // Reset values while held in reset.
        #2;
        chk("rst_base_tick", 32'(base_tick), 32'd0);
        chk("rst_tick",      32'(tick),      32'd0);
        chk("rst_running",   32'(running),   32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_cfg_err",   32'(cfg_err),   32'd0);
        #20 reset_n = 1'b1;

        // ch0 P=3 start accepted at edge 3.
        req(3, 2'd0, 8'd3, 1'b1);
        chk("ch0_acc_ready",   32'(cfg_ready), SYNC ? 32'd0 : 32'd1);
        chk("ch0_acc_running", 32'(running),   SYNC ? 32'd0 : 32'd1);
        to_edge(9);
        chk("e9_base_tick", 32'(base_tick), 32'd0);
        chk("e9_ready",     32'(cfg_ready), SYNC ? 32'd0 : 32'd1);
        to_edge(10);
        chk("e10_base_tick", 32'(base_tick), 32'd1);
        chk("e10_running",   32'(running),   32'd1);
        chk("e10_ready",     32'(cfg_ready), 32'd1);
        chk("e10_tick",      32'(tick),      32'd0);
        to_edge(11);
        chk("e11_base_tick", 32'(base_tick), 32'd0);

        req(12, 2'd1, 8'd1, 1'b1);
        to_edge(20);
        chk("tick@20", 32'(tick), 32'(tk_exp[2]));
        chk("base@20", 32'(base_tick), 32'd1);
        req(22, 2'd2, 8'd2, 1'b1);

        for (int k = 3; k <= 16; k++) begin
            if (!stop_done && stop_edge <= 10 * k) begin
                req(stop_edge, 2'd0, 8'd0, 1'b0);
                stop_done = 1'b1;
            end
            to_edge(10 * k);
            chk($sformatf("tick@%0d", 10 * k), 32'(tick), 32'(tk_exp[k]));
            chk($sformatf("base@%0d", 10 * k), 32'(base_tick), 32'd1);
            if (k == 4) begin
                to_edge(41);
                chk("tick@41", 32'(tick), 32'd0);
                chk("base@41", 32'(base_tick), 32'd0);
            end
        end
        chk("run_after_stop", 32'(running), 32'h6);

        // Reject: start with P=0 on ch3.
        req(162, 2'd3, 8'd0, 1'b1);
        chk("rej_err",   32'(cfg_err),   32'd1);
        chk("rej_ready", 32'(cfg_ready), 32'd1);
        to_edge(163);
        chk("rej_err_clear", 32'(cfg_err), 32'd0);
        to_edge(170);
        chk("rej_running", 32'(running), 32'h6);

        // Reset in the middle of a pending ch3 request.
        req(172, 2'd3, 8'd5, 1'b1);
        to_edge(173);
        chk("pend_ready", 32'(cfg_ready), SYNC ? 32'd0 : 32'd1);
        to_edge(175);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_tick",    32'(tick),      32'd0);
        chk("mid_rst_base",    32'(base_tick), 32'd0);
        chk("mid_rst_running", 32'(running),   32'd0);
        chk("mid_rst_err",     32'(cfg_err),   32'd0);
        chk("mid_rst_ready",   32'(cfg_ready), 32'd1);
        #1 reset_n = 1'b1;
        to_edge(9);
        chk("post_rst_base9", 32'(base_tick), 32'd0);
        to_edge(10);
        chk("post_rst_base10", 32'(base_tick), 32'd1);
        chk("post_rst_running", 32'(running),  32'd0);
        to_edge(60);
        chk("post_rst_tick60", 32'(tick),    32'd0);
        chk("post_rst_run60",  32'(running), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
